// File: rtl/me_pkg.sv
// rtl/me_pkg.sv - shared constants, state encoding and vector helpers for the motion estimator
package me_pkg;

  localparam int DATA_W_DEF         = 8;
  localparam int VEC_W_DEF          = 8;
  localparam int NUM_CANDIDATES_DEF = 256;

  // Saturated distortion value at the default PE accumulate width
  localparam logic [DATA_W_DEF-1:0] SAD_SAT = {DATA_W_DEF{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } me_state_e;

  // Candidate vector index layout for a 16x16 window: {dy[3:0], dx[3:0]}
  localparam int VEC_DX_LSB = 0;
  localparam int VEC_DY_LSB = 4;

  function automatic logic [7:0] pack_vec(input logic [3:0] dx, input logic [3:0] dy);
    logic [7:0] v;
    v = '0;
    v[VEC_DX_LSB +: 4] = dx;
    v[VEC_DY_LSB +: 4] = dy;
    return v;
  endfunction

  // Counter width able to hold the full candidate count without wrapping
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/min_track_cell.sv
// rtl/min_track_cell.sv - registered running-minimum tracker for {distortion, vector}
module min_track_cell #(
  parameter int DATA_W = 8,
  parameter int VEC_W  = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              load_first,
  input  logic              update_en,
  input  logic [DATA_W-1:0] sad_in,
  input  logic [VEC_W-1:0]  vec_in,
  output logic [DATA_W-1:0] min_nxt,
  output logic [VEC_W-1:0]  vec_nxt
);

  logic [DATA_W-1:0] run_min_q, run_min_d;
  logic [VEC_W-1:0]  run_vec_q, run_vec_d;

  // Next running minimum: clear wins, then first-load or strict improvement (ties keep earlier vector)
  always_comb begin
    run_min_d = run_min_q;
    run_vec_d = run_vec_q;
    if (clear) begin
      run_min_d = '1;
      run_vec_d = '0;
    end else if (update_en && (load_first || (sad_in < run_min_q))) begin
      run_min_d = sad_in;
      run_vec_d = vec_in;
    end
  end

  // Exposing the next value lets the owner capture a result on the same edge as the last update
  assign min_nxt = run_min_d;
  assign vec_nxt = run_vec_d;

  // Running minimum registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      run_min_q <= '1;
      run_vec_q <= '0;
    end else begin
      run_min_q <= run_min_d;
      run_vec_q <= run_vec_d;
    end
  end

endmodule

// File: rtl/sad_min_comparator.sv
// rtl/sad_min_comparator.sv - minimum-distortion search over one motion-estimation window
module sad_min_comparator
  import me_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int VEC_W          = VEC_W_DEF,
  parameter int NUM_CANDIDATES = NUM_CANDIDATES_DEF
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic                                  start,
  input  logic                                  sad_valid,
  input  logic [DATA_W-1:0]                     sad_in,
  input  logic [VEC_W-1:0]                      vector_in,
  output logic                                  busy,
  output logic [DATA_W-1:0]                     best_sad,
  output logic [VEC_W-1:0]                      best_vector,
  output logic                                  result_valid,
  output logic [cnt_width(NUM_CANDIDATES)-1:0]  cand_count
);

  localparam int CNT_W = cnt_width(NUM_CANDIDATES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_CANDIDATES - 1);

  me_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cand_count_q, cand_count_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] best_sad_q, best_sad_d;
  logic [VEC_W-1:0]  best_vector_q, best_vector_d;
  logic              result_valid_q, result_valid_d;

  logic              accept;
  logic [DATA_W-1:0] min_nxt;
  logic [VEC_W-1:0]  vec_nxt;

  // A candidate on a start edge belongs to no search and is dropped
  assign accept = (state_q == SEARCH) && sad_valid && !start;

  min_track_cell #(
    .DATA_W (DATA_W),
    .VEC_W  (VEC_W)
  ) u_min (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (start),
    .load_first (cand_count_q == '0),
    .update_en  (accept),
    .sad_in     (sad_in),
    .vec_in     (vector_in),
    .min_nxt    (min_nxt),
    .vec_nxt    (vec_nxt)
  );

  // Search sequencing, candidate counting and result capture
  always_comb begin
    state_d        = state_q;
    cand_count_d   = cand_count_q;
    busy_d         = busy_q;
    best_sad_d     = best_sad_q;
    best_vector_d  = best_vector_q;
    result_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = SEARCH;
          cand_count_d = '0;
          busy_d       = 1'b1;
        end
      end
      SEARCH: begin
        if (start) begin
          cand_count_d = '0;
        end else if (sad_valid) begin
          cand_count_d = cand_count_q + CNT_W'(1);
          if (cand_count_q == LAST_IDX) begin
            state_d        = DONE;
            busy_d         = 1'b0;
            result_valid_d = 1'b1;
            best_sad_d     = min_nxt;
            best_vector_d  = vec_nxt;
          end
        end
      end
      DONE: begin
        if (start) begin
          state_d      = SEARCH;
          cand_count_d = '0;
          busy_d       = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      cand_count_q   <= '0;
      busy_q         <= 1'b0;
      best_sad_q     <= '1;
      best_vector_q  <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cand_count_q   <= cand_count_d;
      busy_q         <= busy_d;
      best_sad_q     <= best_sad_d;
      best_vector_q  <= best_vector_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign busy         = busy_q;
  assign best_sad     = best_sad_q;
  assign best_vector  = best_vector_q;
  assign result_valid = result_valid_q;
  assign cand_count   = cand_count_q;

endmodule
